// File: rtl/multicycle_control_fsm.sv
// Purpose: main sequencer of the multi-cycle RV32I core; decodes IR fields into per-cycle datapath controls.
// Latency: 3-5 cycles per instruction plus one cycle per memory wait; outputs are mostly Moore off state_q.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold, with request strobes stable, until MemReady is seen.
//
// Ports:
//   clk, rst                          clock and asynchronous active-high reset
//   op, funct3, funct7b5              IR[6:0], IR[14:12], IR[30]
//   Zero, LessSigned, LessUnsigned    ALU compare flags, rs1 vs rs2
//   MemReady                          unified memory port finished the current access
//   PCWrite, IRWrite, RegWrite        architectural register write enables
//   MemRead, MemWrite, AdrSrc         memory request strobes and address select
//   ALUSrcA, ALUSrcB, ALUControl      ALU operand selects and operation
//   ImmSrc, ResultSrc, DataControl    immediate format, result mux, load/store size
//   Retire, IllegalOp, State          retire pulse, sticky trap flag, debug state
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       LessSigned,
    input  logic       LessUnsigned,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic [2:0] DataControl,
    output logic       Retire,
    output logic       IllegalOp,
    output logic [3:0] State
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LINK     = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
                           ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_SLT = 4'b1000,
                           ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                           IMM_J = 3'b011, IMM_U = 3'b100;

    logic [3:0] state_q, state_d;

    // alt selects SUB for funct3 000 and SRA for funct3 101.
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_dec = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic lts,
                                      input logic ltu);
        case (f3)
            3'b000:  br_taken = z;
            3'b001:  br_taken = !z;
            3'b100:  br_taken = lts;
            3'b101:  br_taken = !lts;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = !ltu;
            default: br_taken = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_ADD;
        ImmSrc      = IMM_I;
        ResultSrc   = 2'b00;
        DataControl = 3'b000;
        Retire      = 1'b0;
        IllegalOp   = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (MemReady) begin
                    IRWrite   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut <= OldPC + imm, so branch/JAL targets and AUIPC are ready early.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_STORE:          ImmSrc = IMM_S;
                    OP_BRANCH:         ImmSrc = IMM_B;
                    OP_JAL:            ImmSrc = IMM_J;
                    OP_LUI, OP_AUIPC:  ImmSrc = IMM_U;
                    default:           ImmSrc = IMM_I;
                endcase
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = (funct3 == 3'b010 || funct3 == 3'b011)
                                                 ? S_TRAP : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op[5] ? IMM_S : IMM_I;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc      = 1'b1;
                MemRead     = 1'b1;
                DataControl = funct3;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                RegWrite    = 1'b1;
                DataControl = funct3;
                Retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                MemWrite    = 1'b1;
                DataControl = funct3;
                if (MemReady) begin
                    Retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(funct3, funct7b5);
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                // funct7b5 is immediate data for ADDI; it only selects SRAI.
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(funct3, funct7b5 && (funct3 == 3'b101));
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = br_taken(funct3, Zero, LessSigned, LessUnsigned);
                Retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4 for the link.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_d   = S_LINK;
            end
            S_LINK: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ImmSrc    = IMM_U;
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                IllegalOp = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase

        // Reset forces every output low at once, so an aborted access never completes.
        if (rst) begin
            PCWrite     = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            AdrSrc      = 1'b0;
            ALUSrcA     = 2'b00;
            ALUSrcB     = 2'b00;
            ALUControl  = ALU_ADD;
            ImmSrc      = IMM_I;
            ResultSrc   = 2'b00;
            DataControl = 3'b000;
            Retire      = 1'b0;
            IllegalOp   = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, LessSigned, LessUnsigned, MemReady;
    logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB;
    logic [3:0] ALUControl;
    logic [2:0] ImmSrc;
    logic [1:0] ResultSrc;
    logic [2:0] DataControl;
    logic       Retire, IllegalOp;
    logic [3:0] State;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .LessSigned(LessSigned), .LessUnsigned(LessUnsigned),
        .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
        .DataControl(DataControl), .Retire(Retire), .IllegalOp(IllegalOp), .State(State)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mr, mw, adr;
        logic [1:0] sa, sb;
        logic [3:0] alu;
        logic [2:0] imm;
        logic [1:0] res;
        logic [2:0] dc;
        logic       ret, ill;
    } out_t;

    typedef struct {
        int   op, f3, f7, z, ls, lu, rdy;
        out_t exp;
        bit   fwait; // FETCH wait cycle: ALUSrcB/ResultSrc not checked
    } vec_t;

    out_t act;
    assign act = {State, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc, ALUSrcA,
                  ALUSrcB, ALUControl, ImmSrc, ResultSrc, DataControl, Retire, IllegalOp};

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic out_t e(input int st, pcw, irw, rw, mr, mw, adr, sa, sb, alu, imm,
                               res, dc, ret, ill);
        out_t o;
        o.st = st[3:0];  o.pcw = pcw[0]; o.irw = irw[0]; o.rw = rw[0]; o.mr = mr[0];
        o.mw = mw[0];    o.adr = adr[0]; o.sa = sa[1:0]; o.sb = sb[1:0]; o.alu = alu[3:0];
        o.imm = imm[2:0]; o.res = res[1:0]; o.dc = dc[2:0]; o.ret = ret[0]; o.ill = ill[0];
        return o;
    endfunction

    function automatic out_t dec(input int imm);
        return e(1, 0,0,0,0,0,0, 1,1, 0, imm, 0, 0, 0,0);
    endfunction

    task automatic add(input int op_i, f3, f7, z, ls, lu, rdy, input out_t x, input bit fw);
        vec_t v;
        v.op = op_i; v.f3 = f3; v.f7 = f7; v.z = z; v.ls = ls; v.lu = lu; v.rdy = rdy;
        v.exp = x; v.fwait = fw;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input out_t exp, input bit fw);
        out_t m;
        m = '1;
        if (fw) begin
            m.sb  = '0;
            m.res = '0;
        end
        checks++;
        if (((act ^ exp) & m) !== '0) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (state got %0d expected %0d)",
                     name, act, exp, act.st, exp.st);
        end
    endtask

    // Called at a falling edge; drives inputs, checks mid-low-phase, then waits one cycle.
    task automatic apply(input vec_t v, input string name);
        op = v.op[6:0]; funct3 = v.f3[2:0]; funct7b5 = v.f7[0];
        Zero = v.z[0]; LessSigned = v.ls[0]; LessUnsigned = v.lu[0]; MemReady = v.rdy[0];
        #2;
        check(name, v.exp, v.fwait);
        @(negedge clk);
    endtask

    out_t F, FW, WB, TRAP, ZERO;

    initial begin
        F    = e(0, 1,1,0,1,0,0, 0,2, 0,0, 2, 0, 0,0);
        FW   = e(0, 0,0,0,1,0,0, 0,0, 0,0, 0, 0, 0,0);
        WB   = e(8, 0,0,1,0,0,0, 0,0, 0,0, 0, 0, 1,0);
        TRAP = e(14,0,0,0,0,0,0, 0,0, 0,0, 0, 0, 0,1);
        ZERO = '0;

        // R-type SUB; MemReady low outside memory states must be ignored
        add('h33,0,1,0,0,0,1, F, 0);
        add('h33,0,1,0,0,0,0, dec(0), 0);
        add('h33,0,1,0,0,0,0, e(6, 0,0,0,0,0,0, 2,0, 1,0, 0, 0, 0,0), 0);
        add('h33,0,1,0,0,0,0, WB, 0);
        // LBU with 2 fetch waits and 1 read wait: 8 cycles
        add('h03,4,0,0,0,0,0, FW, 1);
        add('h03,4,0,0,0,0,0, FW, 1);
        add('h03,4,0,0,0,0,1, F, 0);
        add('h03,4,0,0,0,0,1, dec(0), 0);
        add('h03,4,0,0,0,0,1, e(2, 0,0,0,0,0,0, 2,1, 0,0, 0, 0, 0,0), 0);
        add('h03,4,0,0,0,0,0, e(3, 0,0,0,1,0,1, 0,0, 0,0, 0, 4, 0,0), 0);
        add('h03,4,0,0,0,0,1, e(3, 0,0,0,1,0,1, 0,0, 0,0, 0, 4, 0,0), 0);
        add('h03,4,0,0,0,0,1, e(4, 0,0,1,0,0,0, 0,0, 0,0, 1, 4, 1,0), 0);
        // BNE not taken, then taken
        add('h63,1,0,1,0,0,1, F, 0);
        add('h63,1,0,1,0,0,1, dec(2), 0);
        add('h63,1,0,1,0,0,1, e(9, 0,0,0,0,0,0, 2,0, 1,0, 0, 0, 1,0), 0);
        add('h63,1,0,0,0,0,1, F, 0);
        add('h63,1,0,0,0,0,1, dec(2), 0);
        add('h63,1,0,0,0,0,1, e(9, 1,0,0,0,0,0, 2,0, 1,0, 0, 0, 1,0), 0);
        // BLT taken on LessSigned, BGEU not taken on LessUnsigned
        add('h63,4,0,0,1,0,1, F, 0);
        add('h63,4,0,0,1,0,1, dec(2), 0);
        add('h63,4,0,0,1,0,1, e(9, 1,0,0,0,0,0, 2,0, 1,0, 0, 0, 1,0), 0);
        add('h63,7,0,0,0,1,1, F, 0);
        add('h63,7,0,0,0,1,1, dec(2), 0);
        add('h63,7,0,0,0,1,1, e(9, 0,0,0,0,0,0, 2,0, 1,0, 0, 0, 1,0), 0);
        // SW with one write wait; Retire only in the ready cycle
        add('h23,2,0,0,0,0,1, F, 0);
        add('h23,2,0,0,0,0,1, dec(1), 0);
        add('h23,2,0,0,0,0,1, e(2, 0,0,0,0,0,0, 2,1, 0,1, 0, 0, 0,0), 0);
        add('h23,2,0,0,0,0,0, e(5, 0,0,0,0,1,1, 0,0, 0,0, 0, 2, 0,0), 0);
        add('h23,2,0,0,0,0,1, e(5, 0,0,0,0,1,1, 0,0, 0,0, 0, 2, 1,0), 0);
        // JAL
        add('h6F,0,0,0,0,0,1, F, 0);
        add('h6F,0,0,0,0,0,1, dec(3), 0);
        add('h6F,0,0,0,0,0,1, e(10,1,0,0,0,0,0, 1,2, 0,0, 0, 0, 0,0), 0);
        add('h6F,0,0,0,0,0,1, WB, 0);
        // JALR: 0,1,11,12,8
        add('h67,0,0,0,0,0,1, F, 0);
        add('h67,0,0,0,0,0,1, dec(0), 0);
        add('h67,0,0,0,0,0,1, e(11,1,0,0,0,0,0, 2,1, 0,0, 2, 0, 0,0), 0);
        add('h67,0,0,0,0,0,1, e(12,0,0,0,0,0,0, 1,2, 0,0, 0, 0, 0,0), 0);
        add('h67,0,0,0,0,0,1, WB, 0);
        // LUI and AUIPC: 3 cycles each
        add('h37,0,0,0,0,0,1, F, 0);
        add('h37,0,0,0,0,0,1, dec(4), 0);
        add('h37,0,0,0,0,0,1, e(13,0,0,1,0,0,0, 0,0, 0,4, 3, 0, 1,0), 0);
        add('h17,0,0,0,0,0,1, F, 0);
        add('h17,0,0,0,0,0,1, dec(4), 0);
        add('h17,0,0,0,0,0,1, WB, 0);
        // ADDI with IR[30]=1 stays ADD; SRAI selects SRA; SLTU R-type
        add('h13,0,1,0,0,0,1, F, 0);
        add('h13,0,1,0,0,0,1, dec(0), 0);
        add('h13,0,1,0,0,0,1, e(7, 0,0,0,0,0,0, 2,1, 0,0, 0, 0, 0,0), 0);
        add('h13,0,1,0,0,0,1, WB, 0);
        add('h13,5,1,0,0,0,1, F, 0);
        add('h13,5,1,0,0,0,1, dec(0), 0);
        add('h13,5,1,0,0,0,1, e(7, 0,0,0,0,0,0, 2,1, 7,0, 0, 0, 0,0), 0);
        add('h13,5,1,0,0,0,1, WB, 0);
        add('h33,3,0,0,0,0,1, F, 0);
        add('h33,3,0,0,0,0,1, dec(0), 0);
        add('h33,3,0,0,0,0,1, e(6, 0,0,0,0,0,0, 2,0, 9,0, 0, 0, 0,0), 0);
        add('h33,3,0,0,0,0,1, WB, 0);
        // Branch funct3 010 is illegal
        add('h63,2,0,0,0,0,1, F, 0);
        add('h63,2,0,0,0,0,1, dec(2), 0);
        add('h63,2,0,0,0,0,1, TRAP, 0);

        // Reset: all outputs low while asserted
        rst = 1'b1; op = '0; funct3 = '0; funct7b5 = 0; Zero = 0;
        LessSigned = 0; LessUnsigned = 0; MemReady = 1'b1;
        repeat (2) @(negedge clk);
        #2 check("reset_outputs", ZERO, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Unknown opcode: TRAP holds with no enables for 20 cycles
        begin
            vec_t v;
            rst = 1'b1; #1 check("trap_clear_rst", ZERO, 0);
            @(negedge clk); rst = 1'b0;
            v = '{op:'h7F, f3:0, f7:0, z:0, ls:0, lu:0, rdy:1, exp:F, fwait:0};
            apply(v, "bad_fetch");
            v.exp = dec(0);
            apply(v, "bad_decode");
            for (int k = 0; k < 20; k++) begin
                v.exp = TRAP;
                v.rdy = k % 2;
                v.z   = k % 3;
                apply(v, $sformatf("trap_hold%0d", k));
            end
            // rst pulse clears IllegalOp and restarts in FETCH
            rst = 1'b1; #1 check("trap_rst_outputs", ZERO, 0);
            @(negedge clk); rst = 1'b0;
            v = '{op:'h23, f3:1, f7:0, z:0, ls:0, lu:0, rdy:0, exp:FW, fwait:1};
            apply(v, "post_trap_fetch_wait");
            v.rdy = 1; v.exp = F; v.fwait = 0;
            apply(v, "st_fetch");
            v.exp = dec(1);
            apply(v, "st_decode");
            v.exp = e(2, 0,0,0,0,0,0, 2,1, 0,1, 0, 0, 0,0);
            apply(v, "st_memadr");
            v.rdy = 0; v.exp = e(5, 0,0,0,0,1,1, 0,0, 0,0, 0, 1, 0,0);
            apply(v, "st_wait");
            // Async reset mid-MEMWRITE, away from any clock edge
            #2 rst = 1'b1;
            #1 check("async_rst_memwrite", ZERO, 0);
            @(negedge clk); rst = 1'b0;
            v.rdy = 1; v.exp = F;
            apply(v, "post_async_fetch");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
